// File: rtl/status_ctrl_pkg.sv
// Shared types and defaults for the status register sequencing controller.
package status_ctrl_pkg;

   localparam int unsigned STATUS_W_DEF    = 4;
   localparam int unsigned STACK_DEPTH_DEF = 4;

   // Status value forced into the register on interrupt entry
   localparam logic [STATUS_W_DEF-1:0] ENTRY_FLAGS_DEF = 4'b0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      POP     = 2'd2,
      RESTORE = 2'd3
   } state_e;

endpackage

// File: rtl/status_lifo.sv
// Shadow stack for saved status values. Push and pop saturate at full and
// empty; rdata_o always shows the entry addressed by the stack pointer, which
// after a pop is the most recently saved value.
module status_lifo
   import status_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = STATUS_W_DEF,
   parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             wdata_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   sp_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int unsigned SPW = $clog2(DEPTH + 1);
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [SPW-1:0]   sp_q, sp_d;
   logic [AW-1:0]    idx;

   assign idx     = AW'(sp_q);
   assign full_o  = (sp_q == SPW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign rdata_o = mem_q[idx];
   assign sp_o    = sp_q;

   // Stack pointer update, never wrapping
   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + SPW'(1);
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - SPW'(1);
      end
   end

   // Stack pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Storage write; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/status_ctrl.sv
// Status register sequencing controller: arbitrates ALU, software and
// interrupt entry/return writes to the status register and keeps a shadow
// stack of saved status across nested interrupts.
// Optional: STATUS_CTRL_ALU_MASK_EN adds alu_mask so an ALU update only
// replaces the masked bits of the current status.
module status_ctrl
   import status_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH       = STATUS_W_DEF,
   parameter int unsigned      DEPTH       = STACK_DEPTH_DEF,
   parameter logic [WIDTH-1:0] ENTRY_FLAGS = WIDTH'(ENTRY_FLAGS_DEF)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           status_cur,
   input  logic                       alu_we,
   input  logic [WIDTH-1:0]           alu_flags,
`ifdef STATUS_CTRL_ALU_MASK_EN
   input  logic [WIDTH-1:0]           alu_mask,
`endif
   input  logic                       sw_we,
   input  logic [WIDTH-1:0]           sw_data,
   input  logic                       irq_req,
   output logic                       irq_ack,
   input  logic                       ret_req,
   output logic                       ret_ack,
   output logic                       busy,
   output logic                       status_load,
   output logic [WIDTH-1:0]           status_next,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       ovf_err,
   output logic                       unf_err
);

   state_e           state_q, state_d;
   logic             load_q, load_d;
   logic [WIDTH-1:0] next_q, next_d;
   logic             iack_q, iack_d;
   logic             rack_q, rack_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] popped_q, popped_d;

   logic             push, pop, full, empty;
   logic [WIDTH-1:0] lifo_rdata;
   logic [WIDTH-1:0] alu_val, eff_status;

   // ALU contribution to the status value
`ifdef STATUS_CTRL_ALU_MASK_EN
   assign alu_val = (status_cur & ~alu_mask) | (alu_flags & alu_mask);
`else
   assign alu_val = alu_flags;
`endif

   // Status as it will be once the instruction retiring this cycle lands
   assign eff_status = sw_we  ? sw_data :
                       alu_we ? alu_val : status_cur;

   status_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (eff_status),
      .rdata_o (lifo_rdata),
      .sp_o    (depth),
      .full_o  (full),
      .empty_o (empty)
   );

   // Arbitration, next state and next registered outputs
   always_comb begin
      state_d  = state_q;
      load_d   = 1'b0;
      next_d   = '0;
      iack_d   = 1'b0;
      rack_d   = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      popped_d = popped_q;
      push     = 1'b0;
      pop      = 1'b0;

      case (state_q)
         IDLE: begin
            if (irq_req) begin
               if (!full) begin
                  push    = 1'b1;
                  state_d = ENTRY;
               end else begin
                  ovf_d  = 1'b1;
                  iack_d = 1'b1;
               end
            end else if (ret_req) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = POP;
               end else begin
                  unf_d  = 1'b1;
                  rack_d = 1'b1;
               end
            end else if (sw_we) begin
               load_d = 1'b1;
               next_d = sw_data;
            end else if (alu_we) begin
               load_d = 1'b1;
               next_d = alu_val;
            end
         end
         ENTRY: begin
            load_d  = 1'b1;
            next_d  = ENTRY_FLAGS;
            iack_d  = 1'b1;
            state_d = IDLE;
         end
         POP: begin
            popped_d = lifo_rdata;
            state_d  = RESTORE;
         end
         RESTORE: begin
            load_d  = 1'b1;
            next_d  = popped_q;
            rack_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         load_q   <= 1'b0;
         next_q   <= '0;
         iack_q   <= 1'b0;
         rack_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         popped_q <= '0;
      end else begin
         state_q  <= state_d;
         load_q   <= load_d;
         next_q   <= next_d;
         iack_q   <= iack_d;
         rack_q   <= rack_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         popped_q <= popped_d;
      end
   end

   assign status_load = load_q;
   assign status_next = next_q;
   assign irq_ack     = iack_q;
   assign ret_ack     = rack_q;
   assign busy        = busy_q;
   assign ovf_err     = ovf_q;
   assign unf_err     = unf_q;

endmodule
